fpu_add_sched: RTL and testbench
================================

Name: fpu_add_sched

Overview:
- Round-robin scheduler that shares one single-precision fp_adder between NUM_REQ requesters.
- Per-requester valid/ready request channel; one common response channel tagged with the requester ID.
- Sequences the adder: one operation in flight at a time. Operands are held stable on the adder. Start is a one-cycle pulse. The result is sampled a fixed RES_LAT cycles after the pulse.
- Sits between the client datapaths and the fp_adder instance; also drives the adder's synchronous reset.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, 2: response ID width; must be at least clog2(NUM_REQ).
- RES_LAT, 5: cycles from the cycle after the fpu_data_valid pulse to the sampling of fpu_sum/fpu_error. Legal range 5..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  32*NUM_REQ  operand A; slice i is [32*i+31:32*i]
- req_b  in  32*NUM_REQ  operand B; slice i is [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester index of the response
- rsp_sum  out  32  IEEE-754 result
- rsp_error  out  1  adder error flag (invalid operation)
- fpu_rst  out  1  synchronous active-high reset to the adder
- fpu_a  out  32  adder operand A
- fpu_b  out  32  adder operand B
- fpu_data_valid  out  1  adder start pulse
- fpu_sum  in  32  adder result
- fpu_error  in  1  adder error
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_error=0, fpu_a=0, fpu_b=0, fpu_data_valid=0, busy=0.
  - fpu_rst=1 during reset and for exactly one clk edge after deassertion, then 0. This returns the adder to its own IDLE.
  - Reset mid-operation abandons the operation; no response is produced.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE (fpu_rst=0):
  - Select grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits are 0. req_ready is 0 in every other state.
  - On the accepting edge: latch req_a[g] into fpu_a, req_b[g] into fpu_b, g into the ID register; go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE: fpu_data_valid=1 for this one cycle only. Load cnt=RES_LAT. Go to WAIT.
- WAIT:
  - Decrement cnt each cycle; fpu_a and fpu_b stay stable.
  - In the cycle where cnt==1: register fpu_sum into rsp_sum and fpu_error into rsp_error; go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_sum and rsp_error stay stable until the handshake (rsp_valid & rsp_ready).
  - On handshake: rr_ptr = (g+1) mod NUM_REQ; go to IDLE.
  - rsp_valid falls the cycle after the handshake. New requests are not accepted in the handshake cycle itself.
  - Backpressure of any length is legal; the adder stays idle meanwhile.
- Latency: accept in cycle 0, start pulse in cycle 1, sample in cycle 1+RES_LAT, rsp_valid first high in cycle 2+RES_LAT (cycle 7 at default).
  - Throughput: one operation per 3+RES_LAT cycles with rsp_ready held at 1.
- Fairness:
  - rr_ptr advances only on a completed response.
  - A requester that drops req_valid before it is granted loses nothing; the scan continues.
  - Requesters must hold req_valid, req_a and req_b stable until req_ready.
- Boundary cases:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - Only requester j valid: granted every round, whatever rr_ptr is.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - req_valid changing during ISSUE/WAIT/RESP has no effect.
- Arithmetic: no computation on operands; values pass through bit-exact. cnt width is 4 bits.

Test Plan:
1. Single op, requester 1, req_a=0x3F800000 (1.0), req_b=0x40000000 (2.0), rsp_ready=1 -> rsp_valid in cycle 7; rsp_id=1, rsp_sum=0x40400000, rsp_error=0; fpu_data_valid high only in cycle 1.
2. All four requesters valid continuously, each with distinct operands -> grants in order 0,1,2,3,0; every rsp_id matches its own operands' sum; one response per 8 cycles.
3. req_a=0x7F800000 (+inf), req_b=0xFF800000 (-inf) -> rsp_sum=0x7FFFFFFF, rsp_error=1. Then 0x7F800000 + 0x3F800000 -> rsp_sum=0x7F800000, rsp_error=0.
4. rsp_ready held 0 for 20 cycles in RESP -> rsp_valid, rsp_id and rsp_sum stay stable; req_ready stays 0 throughout; fpu_data_valid stays 0; on release, the next grant goes to the next requester.
5. rst_n pulled low during WAIT -> all outputs go to reset values immediately; fpu_rst=1 for one edge after release; a new request 1.5+1.5 (0x3FC00000 twice) -> 0x40400000.
6. Only requester 3 valid with rr_ptr=0, then requesters 0 and 3 valid together -> 3 is granted, then 0; the pointer wraps 3 -> 0.

Source files
------------

// File: rtl/fpu_add_sched_if.sv
// -----------------------------------------------------------------------------
// fpu_add_sched_if
// Client-side bundle of the shared fp_adder scheduler.
//   req_valid[NUM_REQ]      per-requester request valid
//   req_a/req_b[32*NUM_REQ] operands, slice i = [32*i+31:32*i]
//   req_ready[NUM_REQ]      one-hot grant/accept
//   rsp_valid/rsp_ready     common response handshake
//   rsp_id/rsp_sum/rsp_error response payload, tagged with requester index
// master: client datapaths; slave: the scheduler.
// -----------------------------------------------------------------------------
interface fpu_add_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) ();
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_sum;
   logic                  rsp_error;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_error
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_error
   );
endinterface

// File: rtl/fpu_add_sched.sv
// -----------------------------------------------------------------------------
// fpu_add_sched
// Round-robin scheduler sharing one single-precision fp_adder between NUM_REQ
// requesters. One operation in flight: operands are latched and held on the
// adder, a one-cycle start pulse is issued, and the result is sampled RES_LAT
// cycles later into a response register tagged with the requester index.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus              request/response bundle (slave side)
//   fpu_rst          synchronous active-high reset to the adder
//   fpu_a, fpu_b     held adder operands
//   fpu_data_valid   adder start pulse
//   fpu_sum, fpu_error adder result inputs
//   busy             high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module fpu_add_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int RES_LAT = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   fpu_add_sched_if.slave    bus,
   output logic              fpu_rst,
   output logic [31:0]       fpu_a,
   output logic [31:0]       fpu_b,
   output logic              fpu_data_valid,
   input  logic [31:0]       fpu_sum,
   input  logic              fpu_error,
   output logic              busy
);
   localparam int DATA_W = 32;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id_q;
   logic [3:0]        cnt;
   logic              fpu_rst_q;
   logic [DATA_W-1:0] fpu_a_q;
   logic [DATA_W-1:0] fpu_b_q;
   logic [DATA_W-1:0] rsp_sum_q;
   logic              rsp_error_q;

   logic [NUM_REQ-1:0] rv_rot;
   logic [ID_W:0]      ofs;
   logic [ID_W:0]      gnt_sum;
   logic [ID_W-1:0]    gnt;
   logic               any_req;
   logic               accept;
   logic [NUM_REQ-1:0] ready_vec;
   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;

   // Grant selection: rotate req_valid so that bit 0 is rr_ptr, take the
   // lowest set bit, then map the offset back to an absolute index.
   always_comb begin
      rv_rot  = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
      any_req = |rv_rot;
      ofs     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rv_rot[k]) ofs = (ID_W+1)'(k);
      end
      gnt_sum = {1'b0, rr_ptr} + ofs;
      if (gnt_sum >= (ID_W+1)'(NUM_REQ)) gnt_sum = gnt_sum - (ID_W+1)'(NUM_REQ);
      gnt = gnt_sum[ID_W-1:0];
   end

   // No grant while the adder is still being held in reset.
   assign accept = (state == IDLE) && !fpu_rst_q && any_req;

   always_comb begin
      ready_vec = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == ID_W'(i)) begin
            ready_vec[i] = accept;
            sel_a        = bus.req_a[DATA_W*i +: DATA_W];
            sel_b        = bus.req_b[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         id_q        <= '0;
         cnt         <= '0;
         fpu_rst_q   <= 1'b1;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         rsp_sum_q   <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         // Adder reset is stretched over exactly one edge after release.
         fpu_rst_q <= 1'b0;
         case (state)
            // Accept stage: latch operands and requester index.
            IDLE: begin
               if (accept) begin
                  fpu_a_q <= sel_a;
                  fpu_b_q <= sel_b;
                  id_q    <= gnt;
                  state   <= ISSUE;
               end
            end
            // Issue stage: start pulse is decoded from this state.
            ISSUE: begin
               cnt   <= 4'(RES_LAT);
               state <= WAIT;
            end
            // Wait stage: result is sampled on the last count.
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_sum_q   <= fpu_sum;
                  rsp_error_q <= fpu_error;
                  state       <= RESP;
               end
            end
            // Response stage: pointer advances only on a completed response.
            RESP: begin
               if (bus.rsp_ready) begin
                  rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = ready_vec;
   assign bus.rsp_valid   = (state == RESP);
   assign bus.rsp_id      = id_q;
   assign bus.rsp_sum     = rsp_sum_q;
   assign bus.rsp_error   = rsp_error_q;
   assign fpu_rst         = fpu_rst_q;
   assign fpu_a           = fpu_a_q;
   assign fpu_b           = fpu_b_q;
   assign fpu_data_valid  = (state == ISSUE);
   assign busy            = (state != IDLE);
endmodule

// File: tb/tb_fpu_add_sched.sv
// -----------------------------------------------------------------------------
// tb_fpu_add_sched
// Directed bench for fpu_add_sched: a table of request patterns with
// hand-computed grants and sums, plus hand-written reset sequences. A small
// adder stand-in returns known sums only in the cycle the scheduler must
// sample them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpu_add_sched;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int RES_LAT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fpu_add_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   logic        fpu_rst;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic        fpu_data_valid;
   logic [31:0] fpu_sum;
   logic        fpu_error;
   logic        busy;

   fpu_add_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .RES_LAT(RES_LAT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .fpu_rst        (fpu_rst),
      .fpu_a          (fpu_a),
      .fpu_b          (fpu_b),
      .fpu_data_valid (fpu_data_valid),
      .fpu_sum        (fpu_sum),
      .fpu_error      (fpu_error),
      .busy           (busy)
   );

   // Adder stand-in: known IEEE-754 sums, presented only RES_LAT cycles
   // after the start pulse; garbage at any other time.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: ref_add = {1'b0, 32'h40400000};
         {32'h7F800000, 32'hFF800000}: ref_add = {1'b1, 32'h7FFFFFFF};
         {32'h7F800000, 32'h3F800000}: ref_add = {1'b0, 32'h7F800000};
         {32'h3FC00000, 32'h3FC00000}: ref_add = {1'b0, 32'h40400000};
         {32'h3F800000, 32'h3F800000}: ref_add = {1'b0, 32'h40000000};
         {32'h40000000, 32'h40000000}: ref_add = {1'b0, 32'h40800000};
         {32'h40800000, 32'h40800000}: ref_add = {1'b0, 32'h41000000};
         {32'h3F800000, 32'h3F000000}: ref_add = {1'b0, 32'h3FC00000};
         default:                      ref_add = {1'b0, 32'hDEADBEEF};
      endcase
   endfunction

   logic [3:0]  m_cnt = 4'd0;
   logic [31:0] m_a   = 32'd0;
   logic [31:0] m_b   = 32'd0;
   always @(posedge clk) begin
      if (fpu_rst) m_cnt <= 4'd0;
      else if (fpu_data_valid) begin
         m_cnt <= 4'd1;
         m_a   <= fpu_a;
         m_b   <= fpu_b;
      end else if (m_cnt != 4'd0 && m_cnt != 4'd15) m_cnt <= m_cnt + 4'd1;
   end
   always_comb begin
      {fpu_error, fpu_sum} = {1'b0, 32'hBADBAD00};
      if (m_cnt == 4'(RES_LAT)) {fpu_error, fpu_sum} = ref_add(m_a, m_b);
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0]   valid;
      logic [127:0] a;
      logic [127:0] b;
      logic [1:0]   id;
      logic [31:0]  sum;
      logic         err;
      logic [5:0]   hold;
      logic         chk_per;
   } vec_t;

   localparam logic [127:0] ALL_A = {32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F800000};
   localparam logic [127:0] ALL_B = {32'h3F000000, 32'h40800000, 32'h40000000, 32'h3F800000};

   int prev_acc = 0;

   // One operation: grant check in IDLE, accept, next pattern applied while
   // busy, latency/pulse checks, optional backpressure, handshake.
   task automatic run_vec(input vec_t v, input vec_t n, input string tag);
      int          k;
      int          acc;
      int          bad;
      int          bad2;
      logic        got;
      logic [31:0] ea;
      logic [31:0] eb;
      ea = v.a[32*v.id +: 32];
      eb = v.b[32*v.id +: 32];
      @(negedge clk);
      chk({tag, " rsp_valid_idle"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, " fpu_rst_idle"}, 32'(fpu_rst), 32'd0);
      chk({tag, " grant"}, 32'(bus.req_ready), 32'(4'b0001 << v.id));
      @(posedge clk);
      #1;
      acc = cyc;
      if (v.chk_per) chk({tag, " period"}, 32'(acc - prev_acc), 32'(3 + RES_LAT));
      prev_acc      = acc;
      bus.rsp_ready = (v.hold == 6'd0);
      bus.req_valid = n.valid;
      bus.req_a     = n.a;
      bus.req_b     = n.b;
      k   = 1;
      got = 1'b0;
      bad = 0;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         if (fpu_data_valid !== (k == 1)) bad++;
         if (bus.req_ready !== 4'b0000) bad++;
         if (bus.rsp_valid === 1'b1) got = 1'b1;
         else begin
            @(posedge clk);
            k++;
         end
      end
      chk({tag, " rsp_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(k), 32'(2 + RES_LAT));
      chk({tag, " pulse_ready_bad"}, 32'(bad), 32'd0);
      chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
      chk({tag, " rsp_sum"}, bus.rsp_sum, v.sum);
      chk({tag, " rsp_error"}, 32'(bus.rsp_error), 32'(v.err));
      chk({tag, " fpu_a"}, fpu_a, ea);
      chk({tag, " fpu_b"}, fpu_b, eb);
      bad2 = 0;
      for (int h = 0; h < int'(v.hold); h++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== v.id || bus.rsp_sum !== v.sum ||
             bus.req_ready !== 4'b0000 || fpu_data_valid !== 1'b0 || busy !== 1'b1) bad2++;
      end
      if (v.hold != 6'd0) chk({tag, " hold_stable"}, 32'(bad2), 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
   endtask

   vec_t vt[13];
   vec_t idle_v;
   vec_t r5;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{4'b0010, {32'h0, 32'h0, 32'h3F800000, 32'h0}, {32'h0, 32'h0, 32'h40000000, 32'h0},
                 2'd1, 32'h40400000, 1'b0, 6'd0, 1'b0};
      vt[1]  = '{4'b0100, {32'h0, 32'h7F800000, 32'h0, 32'h0}, {32'h0, 32'hFF800000, 32'h0, 32'h0},
                 2'd2, 32'h7FFFFFFF, 1'b1, 6'd0, 1'b1};
      vt[2]  = '{4'b1000, {32'h7F800000, 32'h0, 32'h0, 32'h0}, {32'h3F800000, 32'h0, 32'h0, 32'h0},
                 2'd3, 32'h7F800000, 1'b0, 6'd0, 1'b1};
      vt[3]  = '{4'b1111, ALL_A, ALL_B, 2'd0, 32'h40000000, 1'b0, 6'd0, 1'b1};
      vt[4]  = '{4'b1111, ALL_A, ALL_B, 2'd1, 32'h40800000, 1'b0, 6'd0, 1'b1};
      vt[5]  = '{4'b1111, ALL_A, ALL_B, 2'd2, 32'h41000000, 1'b0, 6'd0, 1'b1};
      vt[6]  = '{4'b1111, ALL_A, ALL_B, 2'd3, 32'h3FC00000, 1'b0, 6'd0, 1'b1};
      vt[7]  = '{4'b1111, ALL_A, ALL_B, 2'd0, 32'h40000000, 1'b0, 6'd0, 1'b1};
      vt[8]  = '{4'b1111, ALL_A, ALL_B, 2'd1, 32'h40800000, 1'b0, 6'd19, 1'b1};
      vt[9]  = '{4'b1111, ALL_A, ALL_B, 2'd2, 32'h41000000, 1'b0, 6'd0, 1'b0};
      vt[10] = '{4'b1000, ALL_A, ALL_B, 2'd3, 32'h3FC00000, 1'b0, 6'd0, 1'b1};
      vt[11] = '{4'b1000, ALL_A, ALL_B, 2'd3, 32'h3FC00000, 1'b0, 6'd0, 1'b1};
      vt[12] = '{4'b1001, ALL_A, ALL_B, 2'd0, 32'h40000000, 1'b0, 6'd0, 1'b1};
      idle_v = '0;
      r5     = '{4'b0101, {32'h0, 32'h3FC00000, 32'h0, 32'h3FC00000},
                 {32'h0, 32'h3FC00000, 32'h0, 32'h3FC00000},
                 2'd0, 32'h40400000, 1'b0, 6'd0, 1'b0};

      // Power-on reset with requests already pending.
      bus.rsp_ready = 1'b1;
      bus.req_valid = vt[0].valid;
      bus.req_a     = vt[0].a;
      bus.req_b     = vt[0].b;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst rsp_sum", bus.rsp_sum, 32'd0);
      chk("rst rsp_error", 32'(bus.rsp_error), 32'd0);
      chk("rst fpu_a", fpu_a, 32'd0);
      chk("rst fpu_b", fpu_b, 32'd0);
      chk("rst fpu_data_valid", 32'(fpu_data_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst fpu_rst", 32'(fpu_rst), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel fpu_rst_held", 32'(fpu_rst), 32'd1);
      chk("rel no_grant", 32'(bus.req_ready), 32'd0);
      @(posedge clk);

      for (int i = 0; i < 13; i++) begin
         run_vec(vt[i], (i < 12) ? vt[i+1] : idle_v, $sformatf("v%0d", i));
      end

      // Reset in the middle of WAIT abandons the operation.
      #1;
      bus.req_valid = 4'b0010;
      bus.req_a     = {32'h0, 32'h0, 32'h3FC00000, 32'h0};
      bus.req_b     = {32'h0, 32'h0, 32'h3FC00000, 32'h0};
      @(negedge clk);
      chk("r5 grant_pre", 32'(bus.req_ready), 32'b0010);
      @(posedge clk);
      #1 bus.req_valid = 4'b0000;
      repeat (3) @(posedge clk);
      #2;
      chk("r5 busy_pre", 32'(busy), 32'd1);
      rst_n         = 1'b0;
      bus.req_valid = r5.valid;
      bus.req_a     = r5.a;
      bus.req_b     = r5.b;
      #1;
      chk("r5 busy", 32'(busy), 32'd0);
      chk("r5 rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("r5 fpu_a", fpu_a, 32'd0);
      chk("r5 fpu_b", fpu_b, 32'd0);
      chk("r5 fpu_rst", 32'(fpu_rst), 32'd1);
      chk("r5 req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("r5 fpu_rst_held", 32'(fpu_rst), 32'd1);
      chk("r5 no_grant", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      run_vec(r5, idle_v, "r5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
